// File: rtl/iob_regfile_t2p.sv
// iob_regfile_t2p: 2**ADDR_W x DATA_W register array, one write port, one combinational read port.
module iob_regfile_t2p #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 21
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [DATA_W-1:0] ent_q;
    always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) ent_q <= '0;
      else if (cke_i && we_i && waddr_i == ADDR_W'(g)) ent_q <= wdata_i;
    end
    assign mem[g] = ent_q;
  end
  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/iob_regfile_fifo.sv
// iob_regfile_fifo: FWFT synchronous FIFO on a register-file array; pointers carry an extra wrap bit.
module iob_regfile_fifo #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 21
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic              flush_i,
  input  logic              w_valid_i,
  output logic              w_ready_o,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              r_valid_o,
  input  logic              r_ready_i,
  output logic [DATA_W-1:0] r_data_o,
  output logic [ADDR_W:0]   level_o
);
  localparam int PTR_W = ADDR_W + 1;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic push, pop, full, empty;
  logic [DATA_W-1:0] rdata;
  assign empty = wptr_q == rptr_q;
  assign full = wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0] && wptr_q[ADDR_W] != rptr_q[ADDR_W];
  assign w_ready_o = !full;
  assign r_valid_o = !empty;
  // flush discards any same-cycle transfer, including the storage write
  assign push = w_valid_i && !full && cke_i && !flush_i;
  assign pop = r_ready_i && !empty && cke_i && !flush_i;
  always_comb begin
    wptr_d = flush_i ? '0 : wptr_q + PTR_W'(push);
    rptr_d = flush_i ? '0 : rptr_q + PTR_W'(pop);
    level_d = flush_i ? '0 : (push && !pop) ? level_q + PTR_W'(1) : (pop && !push) ? level_q - PTR_W'(1) : level_q;
  end
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
    end else if (cke_i) begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
    end
  end
  iob_regfile_t2p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rf (
    .clk_i   (clk_i),
    .arst_n_i(arst_n_i),
    .cke_i   (cke_i),
    .we_i    (push),
    .waddr_i (wptr_q[ADDR_W-1:0]),
    .wdata_i (w_data_i),
    .raddr_i (rptr_q[ADDR_W-1:0]),
    .rdata_o (rdata)
  );
  assign r_data_o = empty ? '0 : rdata;
  assign level_o = level_q;
endmodule

// File: tb/tb_iob_regfile_fifo.sv
// tb_iob_regfile_fifo: directed vector table plus randomized traffic against a queue reference model.
module tb_iob_regfile_fifo;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 21;
  localparam int DEPTH = 4;
  logic clk = 0, cke = 1, arst_n = 0, flush = 0, w_valid = 0, r_ready = 0;
  logic [DATA_W-1:0] w_data = '0;
  logic w_ready, r_valid;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W:0] level;
  int checks = 0, errors = 0;
  logic [DATA_W-1:0] q[$];
  iob_regfile_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .flush_i(flush),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data), .level_o(level)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic c, f, wv, rr;
    logic [DATA_W-1:0] wd;
    int lvl;
    logic wr, rv;
    logic [DATA_W-1:0] rd;
  } vec_t;
  vec_t vt[16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_model();
    chk("level", 32'(level), 32'(q.size()));
    chk("w_ready", 32'(w_ready), 32'(q.size() < DEPTH));
    chk("r_valid", 32'(r_valid), 32'(q.size() > 0));
    chk("r_data", 32'(r_data), q.size() > 0 ? 32'(q[0]) : 32'h0);
  endtask
  task automatic step(input logic c, input logic f, input logic wv, input logic [DATA_W-1:0] wd, input logic rr);
    bit do_push, do_pop;
    cke = c; flush = f; w_valid = wv; w_data = wd; r_ready = rr;
    do_push = c && !f && wv && q.size() < DEPTH;
    do_pop = c && !f && rr && q.size() > 0;
    @(posedge clk);
    if (c && f) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(wd);
    end
    @(negedge clk);
    chk_model();
  endtask
  initial begin
    vt[0]  = '{1,0,1,0,21'h1,1,1,1,21'h1};
    vt[1]  = '{1,0,1,0,21'h2,2,1,1,21'h1};
    vt[2]  = '{1,0,1,0,21'h3,3,1,1,21'h1};
    vt[3]  = '{1,0,1,0,21'h4,4,0,1,21'h1};
    vt[4]  = '{1,0,1,0,21'h5,4,0,1,21'h1};
    vt[5]  = '{1,0,1,1,21'h5,3,1,1,21'h2};
    vt[6]  = '{1,0,0,1,21'h0,2,1,1,21'h3};
    vt[7]  = '{1,0,0,1,21'h0,1,1,1,21'h4};
    vt[8]  = '{1,0,0,1,21'h0,0,1,0,21'h0};
    vt[9]  = '{1,0,1,1,21'h6,1,1,1,21'h6};
    vt[10] = '{1,0,1,0,21'h7,2,1,1,21'h6};
    vt[11] = '{0,0,1,1,21'h8,2,1,1,21'h6};
    vt[12] = '{1,1,1,1,21'h9,0,1,0,21'h0};
    vt[13] = '{1,0,1,0,21'hA,1,1,1,21'hA};
    vt[14] = '{0,1,0,0,21'h0,1,1,1,21'hA};
    vt[15] = '{1,0,0,1,21'h0,0,1,0,21'h0};
    #2;
    chk("rst_level", 32'(level), 0);
    chk("rst_w_ready", 32'(w_ready), 1);
    chk("rst_r_valid", 32'(r_valid), 0);
    chk("rst_r_data", 32'(r_data), 0);
    @(negedge clk);
    arst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      step(vt[i].c, vt[i].f, vt[i].wv, vt[i].wd, vt[i].rr);
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vt[i].lvl));
      chk($sformatf("vec%0d_w_ready", i), 32'(w_ready), 32'(vt[i].wr));
      chk($sformatf("vec%0d_r_valid", i), 32'(r_valid), 32'(vt[i].rv));
      chk($sformatf("vec%0d_r_data", i), 32'(r_data), 32'(vt[i].rd));
    end
    begin
      int sent = 0;
      int got = 0;
      int guard = 0;
      while (got < 10 && guard < 200) begin
        logic rr;
        logic [DATA_W-1:0] exp_word;
        bit will_pop;
        rr = 1'($urandom_range(0, 2) != 0);
        will_pop = rr && q.size() > 0;
        exp_word = 21'h10 + 21'(got);
        if (will_pop) chk("wrap_order", 32'(r_data), 32'(exp_word));
        step(1, 0, sent < 10, 21'h10 + 21'(sent), rr);
        if (will_pop) got++;
        if (sent < 10 && w_valid && q.size() > 0 && q[q.size()-1] == 21'h10 + 21'(sent)) sent++;
        if (level > 4) chk("wrap_level_max", 32'(level), 4);
        guard++;
      end
      chk("wrap_done", 32'(got), 10);
    end
    step(1, 0, 1, 21'h21, 0);
    step(1, 0, 1, 21'h22, 0);
    step(1, 0, 1, 21'h23, 0);
    #2 arst_n = 0;
    #1;
    q.delete();
    chk("arst_level", 32'(level), 0);
    chk("arst_w_ready", 32'(w_ready), 1);
    chk("arst_r_valid", 32'(r_valid), 0);
    chk("arst_r_data", 32'(r_data), 0);
    @(negedge clk);
    arst_n = 1;
    @(negedge clk);
    begin
      logic hold_v;
      logic [DATA_W-1:0] hold_d;
      bit acc;
      hold_v = 0;
      hold_d = '0;
      for (int n = 0; n < 400; n++) begin
        logic c, f, wv, rr;
        logic [DATA_W-1:0] wd;
        c = 1'($urandom_range(0, 7) != 0);
        f = 1'($urandom_range(0, 40) == 0);
        rr = 1'($urandom_range(0, 1));
        if (hold_v) begin wv = 1; wd = hold_d; end
        else begin wv = 1'($urandom_range(0, 2) != 0); wd = DATA_W'($urandom); end
        acc = c && !f && q.size() < DEPTH;
        step(c, f, wv, wd, rr);
        hold_v = wv && !acc && !(c && f);
        hold_d = wd;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
